// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - requester and TX FIFO handshake bundle for uart_tx_sched (DMA signals under UART_TX_DMA_EN)
interface uart_tx_sched_if;
    logic       cpu_req;
    logic [7:0] cpu_data;
    logic       cpu_ack;
`ifdef UART_TX_DMA_EN
    logic       dma_req;
    logic [7:0] dma_data;
    logic       dma_ack;
`endif
    logic       tx_nf;
    logic       tx_busy;
    logic       ctrl_en;
    logic       ctrl_tx_en;
    logic [7:0] ctrl_data;
    logic       ctrl_shift_tx;

    // Requesters and the transmitter model drive this side.
    modport master (
        output cpu_req, cpu_data,
        input  cpu_ack,
`ifdef UART_TX_DMA_EN
        output dma_req, dma_data,
        input  dma_ack,
`endif
        output tx_nf, tx_busy,
        input  ctrl_en, ctrl_tx_en, ctrl_data, ctrl_shift_tx
    );

    modport slave (
        input  cpu_req, cpu_data,
        output cpu_ack,
`ifdef UART_TX_DMA_EN
        input  dma_req, dma_data,
        output dma_ack,
`endif
        input  tx_nf, tx_busy,
        output ctrl_en, ctrl_tx_en, ctrl_data, ctrl_shift_tx
    );
endinterface

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART TX enable FSM, bit tick divider and FIFO write arbiter; UART_TX_DMA_EN adds the DMA requester
module uart_tx_sched #(
    parameter int DIV_W = 16
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    output logic [1:0]       sts_state,
    uart_tx_sched_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_OFF   = 2'b00,
        ST_RUN   = 2'b01,
        ST_DRAIN = 2'b10
    } state_t;

    state_t           state;
    logic             en_q;
    logic             shift_q;
    logic             idle_q;
    logic [DIV_W-1:0] cnt;

    logic             cnt_zero;
    logic [DIV_W-1:0] cnt_step;

    assign cnt_zero = (cnt == '0);
    assign cnt_step = cnt_zero ? cfg_div : cnt - DIV_W'(1);

    // idle_q remembers that tx_busy was already low on the previous DRAIN cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state   <= ST_OFF;
            en_q    <= 1'b0;
            shift_q <= 1'b0;
            idle_q  <= 1'b0;
            cnt     <= '0;
        end else begin
            shift_q <= 1'b0;
            idle_q  <= 1'b0;
            case (state)
                ST_OFF: begin
                    if (cfg_en) begin
                        state <= ST_RUN;
                        en_q  <= 1'b1;
                        cnt   <= cfg_div;
                    end else begin
                        cnt <= '0;
                    end
                end
                ST_RUN: begin
                    shift_q <= cnt_zero;
                    cnt     <= cnt_step;
                    if (!cfg_en) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cfg_en) begin
                        state   <= ST_RUN;
                        shift_q <= cnt_zero;
                        cnt     <= cnt_step;
                    end else if (!bus.tx_busy && idle_q) begin
                        state <= ST_OFF;
                        en_q  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        idle_q  <= !bus.tx_busy;
                        shift_q <= cnt_zero;
                        cnt     <= cnt_step;
                    end
                end
                default: begin
                    state <= ST_OFF;
                    en_q  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Grants use the registered state, so the cycle cfg_en falls can still grant.
    logic elig;
    logic cpu_gnt;

    assign elig = (state == ST_RUN) && bus.tx_nf;

`ifdef UART_TX_DMA_EN
    logic dma_gnt;
    logic ptr;

    assign cpu_gnt = elig && bus.cpu_req && (!bus.dma_req || !ptr);
    assign dma_gnt = elig && bus.dma_req && (!bus.cpu_req || ptr);

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ptr <= 1'b0;
        end else if (cpu_gnt) begin
            ptr <= 1'b1;
        end else if (dma_gnt) begin
            ptr <= 1'b0;
        end
    end

    assign bus.dma_ack    = dma_gnt;
    assign bus.ctrl_tx_en = cpu_gnt || dma_gnt;
    assign bus.ctrl_data  = cpu_gnt ? bus.cpu_data :
                            dma_gnt ? bus.dma_data : 8'h00;
`else
    assign cpu_gnt        = elig && bus.cpu_req;
    assign bus.ctrl_tx_en = cpu_gnt;
    assign bus.ctrl_data  = cpu_gnt ? bus.cpu_data : 8'h00;
`endif

    assign bus.cpu_ack       = cpu_gnt;
    assign bus.ctrl_en       = en_q;
    assign bus.ctrl_shift_tx = shift_q;
    assign sts_state         = state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    logic        pclk;
    logic        preset_n;
    logic        cfg_en;
    logic [15:0] cfg_div;
    logic [1:0]  sts_state;

    uart_tx_sched_if bus();

    uart_tx_sched #(.DIV_W(16)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .sts_state (sts_state),
        .bus       (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit tick_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // With cfg_div=3 entered at cycle 0, ticks land on cycles 5, 9, 13, ...
    task automatic step();
        @(posedge pclk);
        #1;
        cyc++;
        if (tick_chk)
            check($sformatf("tick_c%0d", cyc), {31'd0, bus.ctrl_shift_tx},
                  {31'd0, (cyc >= 5) && (cyc % 4 == 1)});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_en"},    {31'd0, bus.ctrl_en},       32'd0);
        check({tag, "_shift"}, {31'd0, bus.ctrl_shift_tx}, 32'd0);
        check({tag, "_txen"},  {31'd0, bus.ctrl_tx_en},    32'd0);
        check({tag, "_ack"},   {31'd0, bus.cpu_ack},       32'd0);
        check({tag, "_data"},  {24'd0, bus.ctrl_data},     32'd0);
        check({tag, "_sts"},   {30'd0, sts_state},         32'd0);
    endtask

    initial begin
        preset_n     = 1'b0;
        cfg_en       = 1'b0;
        cfg_div      = 16'd3;
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 8'h77;
        bus.tx_nf    = 1'b1;
        bus.tx_busy  = 1'b0;
`ifdef UART_TX_DMA_EN
        bus.dma_req  = 1'b0;
        bus.dma_data = 8'h00;
`endif
        repeat (3) @(posedge pclk);
        #1;
        check_idle_outputs("rst");

        preset_n = 1'b1;
        step();
        step();
        check("off_sts", {30'd0, sts_state}, 32'd0);
        check("off_ack", {31'd0, bus.cpu_ack}, 32'd0);
        check("off_en", {31'd0, bus.ctrl_en}, 32'd0);
        bus.cpu_req = 1'b0;

        // Tick period: enable at cycle 0
        cfg_en = 1'b1;
        cyc = 0;
        tick_chk = 1'b1;
        step();
        check("run_en_c1", {31'd0, bus.ctrl_en}, 32'd1);
        check("run_sts_c1", {30'd0, sts_state}, 32'd1);
        repeat (13) step();
        check("run_en_c14", {31'd0, bus.ctrl_en}, 32'd1);

        // Back-to-back CPU writes, one per cycle
        for (int i = 0; i < 3; i++) begin
            step();
            bus.cpu_req  = 1'b1;
            bus.cpu_data = (i == 0) ? 8'hA5 : (i == 1) ? 8'h81 : 8'hFF;
            #1;
            check("wr_ack", {31'd0, bus.cpu_ack}, 32'd1);
            check("wr_txen", {31'd0, bus.ctrl_tx_en}, 32'd1);
            check("wr_data", {24'd0, bus.ctrl_data}, (i == 0) ? 32'hA5 : (i == 1) ? 32'h81 : 32'hFF);
        end

        // Backpressure
        for (int i = 0; i < 4; i++) begin
            step();
            bus.tx_nf = 1'b0;
            #1;
            check("bp_ack", {31'd0, bus.cpu_ack}, 32'd0);
            check("bp_txen", {31'd0, bus.ctrl_tx_en}, 32'd0);
            check("bp_data", {24'd0, bus.ctrl_data}, 32'd0);
        end
        step();
        bus.tx_nf = 1'b1;
        #1;
        check("bp_release_ack", {31'd0, bus.cpu_ack}, 32'd1);
        bus.cpu_req = 1'b0;

`ifdef UART_TX_DMA_EN
        // Last grant went to CPU, so DMA is favoured first.
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 8'hA5;
        bus.dma_req  = 1'b1;
        bus.dma_data = 8'h3C;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            check("rr_cpu_ack", {31'd0, bus.cpu_ack}, (i % 2 == 1) ? 32'd1 : 32'd0);
            check("rr_dma_ack", {31'd0, bus.dma_ack}, (i % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_data", {24'd0, bus.ctrl_data}, (i % 2 == 0) ? 32'h3C : 32'hA5);
        end
        // Last grant was CPU; DMA alone is granted, then alone again despite the pointer.
        step();
        bus.cpu_req = 1'b0;
        #1;
        check("solo_dma_ack", {31'd0, bus.dma_ack}, 32'd1);
        step();
        check("solo_dma_ack2", {31'd0, bus.dma_ack}, 32'd1);
        check("solo_dma_data", {24'd0, bus.ctrl_data}, 32'h3C);
        bus.dma_req = 1'b0;
`endif

        // cfg_en falls with a request pending: that cycle still grants
        step();
        bus.cpu_req  = 1'b1;
        bus.cpu_data = 8'h42;
        cfg_en       = 1'b0;
        bus.tx_busy  = 1'b1;
        #1;
        check("fall_ack", {31'd0, bus.cpu_ack}, 32'd1);
        check("fall_data", {24'd0, bus.ctrl_data}, 32'h42);
        for (int i = 0; i < 6; i++) begin
            step();
            check("drain_sts", {30'd0, sts_state}, 32'd2);
            check("drain_en", {31'd0, bus.ctrl_en}, 32'd1);
            check("drain_ack", {31'd0, bus.cpu_ack}, 32'd0);
            check("drain_txen", {31'd0, bus.ctrl_tx_en}, 32'd0);
        end

        // Re-enable during drain
        cfg_en = 1'b1;
        step();
        check("reen_sts", {30'd0, sts_state}, 32'd1);
        check("reen_en", {31'd0, bus.ctrl_en}, 32'd1);
        check("reen_ack", {31'd0, bus.cpu_ack}, 32'd1);
        bus.cpu_req = 1'b0;
        step();

        // Drain with tx_busy high for 20 cycles, one-cycle low glitch, then exit
        cfg_en = 1'b0;
        bus.cpu_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("drain2_sts", {30'd0, sts_state}, 32'd2);
            check("drain2_ack", {31'd0, bus.cpu_ack}, 32'd0);
        end
        bus.tx_busy = 1'b0;
        step();
        check("glitch_sts", {30'd0, sts_state}, 32'd2);
        bus.tx_busy = 1'b1;
        step();
        check("glitch_sts2", {30'd0, sts_state}, 32'd2);
        bus.tx_busy = 1'b0;
        step();
        check("exit_pre_sts", {30'd0, sts_state}, 32'd2);
        check("exit_pre_en", {31'd0, bus.ctrl_en}, 32'd1);
        tick_chk = 1'b0;
        step();
        check("exit_sts", {30'd0, sts_state}, 32'd0);
        check("exit_en", {31'd0, bus.ctrl_en}, 32'd0);
        check("exit_shift", {31'd0, bus.ctrl_shift_tx}, 32'd0);
        step();
        check("off2_shift", {31'd0, bus.ctrl_shift_tx}, 32'd0);
        check("off2_ack", {31'd0, bus.cpu_ack}, 32'd0);

        // cfg_div=0 ticks every cycle, then reset mid-frame
        cfg_div = 16'd0;
        cfg_en  = 1'b1;
        cyc = 0;
        step();
        check("div0_en_c1", {31'd0, bus.ctrl_en}, 32'd1);
        check("div0_tick_c1", {31'd0, bus.ctrl_shift_tx}, 32'd0);
        step();
        check("div0_tick_c2", {31'd0, bus.ctrl_shift_tx}, 32'd1);
        step();
        check("div0_tick_c3", {31'd0, bus.ctrl_shift_tx}, 32'd1);
        check("mid_ack", {31'd0, bus.cpu_ack}, 32'd1);
        #2;
        preset_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        step();
        step();
        cfg_en = 1'b0;
        preset_n = 1'b1;
        step();
        step();
        check("post_rst_sts", {30'd0, sts_state}, 32'd0);
        check("post_rst_en", {31'd0, bus.ctrl_en}, 32'd0);
        cfg_en = 1'b1;
        step();
        check("post_rst_run", {30'd0, sts_state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Sequencing and arbitration front end for the UART transmit path. Generates the transmitter enable, the per-bit shift tick from a programmable divisor, and the TX FIFO write strobe. Arbitrates FIFO writes between the APB register requester and an optional streaming (DMA) requester. Performs a graceful drain on software disable so a frame in flight is not truncated.

## Interface
- `DIV_W`, 16: width of the baud divisor.
- `pclk`  in  1  system clock.
- `preset_n`  in  1  asynchronous reset, active low.
- `cfg_en`  in  1  software UART enable.
- `cfg_div`  in  DIV_W  bit period minus one, in pclk cycles.
- `cpu_req`  in  1  CPU write request; held until `cpu_ack`.
- `cpu_data`  in  8  CPU write byte.
- `cpu_ack`  out  1  CPU byte accepted this cycle.
- `dma_req`  in  1  DMA write request; held until `dma_ack`. Present only with the macro.
- `dma_data`  in  8  DMA write byte. Present only with the macro.
- `dma_ack`  out  1  DMA byte accepted this cycle. Present only with the macro.
- `tx_nf`  in  1  transmitter FIFO not full.
- `tx_busy`  in  1  transmitter busy (shifting, or FIFO above threshold).
- `ctrl_en`  out  1  transmitter enable.
- `ctrl_tx_en`  out  1  FIFO write strobe.
- `ctrl_data`  out  8  FIFO write byte.
- `ctrl_shift_tx`  out  1  one-cycle bit tick.
- `sts_state`  out  2  FSM state: 00 OFF, 01 RUN, 10 DRAIN.

## Operation
- **FSM, registered.**
  - OFF→RUN when `cfg_en`=1.
  - RUN→DRAIN when `cfg_en`=0.
  - DRAIN→RUN when `cfg_en`=1.
  - DRAIN→OFF when `tx_busy`=0 for 2 consecutive cycles.
- **Enable.** `ctrl_en` is 1 in RUN and DRAIN, and 0 in OFF. It is a decoded registered output.
- **Drain completeness.** A complete drain relies on the transmitter threshold being set to "empty". With a higher threshold, residual FIFO bytes are flushed when `ctrl_en` falls; this is accepted behaviour.
- **Tick counter.** DIV_W-bit down-counter.
  - Loads `cfg_div` on entry to RUN from OFF.
  - At 0: `ctrl_shift_tx`=1 for one cycle, then reload `cfg_div`. Otherwise decrement.
  - Counts in RUN and DRAIN. Held at 0 with no tick in OFF.
  - A `cfg_div` change takes effect at the next reload.
  - `cfg_div`=0 gives a tick every cycle.
- **Arbitration.**
  - Grants are issued only in RUN with `tx_nf`=1. At most one grant per cycle.
  - Round-robin over CPU/DMA. The 1-bit pointer is registered and flips to the other requester after each grant.
  - If only one requester is active, it is granted regardless of the pointer.
  - Grant is combinational: `ctrl_tx_en`=grant, `ctrl_data`=granted byte (0 when no grant), and the matching ack is asserted in the same cycle.
- **No grants in OFF or DRAIN.** Requests stay pending and receive no ack; a requester may withdraw.

## Timing
- **Reset values** (asynchronous): state OFF, `ctrl_en`=0, `ctrl_shift_tx`=0, counter 0, pointer favours CPU, `ctrl_tx_en`/`cpu_ack`/`dma_ack`=0, `ctrl_data`=0, `sts_state`=00.
- **Enable latency.** `cfg_en` rising → `ctrl_en` high 1 cycle later → first tick `cfg_div`+1 cycles after `ctrl_en` rises.
- **Write latency.** 0 cycles request→ack when eligible. Sustained throughput is one byte per cycle while `tx_nf`=1.
- **Full FIFO.** `tx_nf`=0 blocks all acks in that cycle. No byte is lost, because the requester holds.
- **`cfg_en` falls while a request is pending.** A grant can still occur in the same cycle, because RUN is still the registered state. The next cycle is DRAIN with no grants.
- **Reset mid-frame.** All outputs return to reset values immediately. The transmitter is disabled via `ctrl_en`=0.

## Configuration
- `UART_TX_DMA_EN` defined: DMA ports exist and round-robin arbitration applies.
- `UART_TX_DMA_EN` undefined:
  - DMA ports and the pointer are absent.
  - `cpu_ack` = `cpu_req` & `tx_nf` & RUN.
  - `ctrl_data` = `cpu_data` when acked, else 0.

## Test plan
1. **Tick period.** `cfg_div`=3, `cfg_en`=1 → `ctrl_en` high at cycle 1, `ctrl_shift_tx` pulses at cycles 5, 9, 13, …, each 1 cycle wide.
2. **Round-robin.** Both requesters held (CPU 0xA5, DMA 0x3C), `tx_nf`=1 → acks alternate CPU, DMA, CPU…; `ctrl_data` alternates 0xA5/0x3C every cycle.
3. **Backpressure.** `tx_nf`=0 for 4 cycles with `cpu_req` held → no `cpu_ack` and `ctrl_tx_en`=0 throughout; ack in the first cycle `tx_nf` returns to 1.
4. **Drain.** `cfg_en` dropped while `tx_busy`=1 for 20 cycles → `sts_state`=10, ticks continue, no acks; `ctrl_en` falls 2 cycles after `tx_busy` goes low; `sts_state`=00.
5. **Re-enable during drain.** `cfg_en` reasserted in DRAIN → back to RUN, `ctrl_en` never deasserted, tick phase uninterrupted.
6. **Reset mid-frame.** `preset_n` asserted mid-frame → all outputs 0 asynchronously; after release, state OFF until `cfg_en`.
